// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, operation codes,
// port index and the latched transaction descriptor.
package ram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   typedef logic [0:0] port_idx_t;

   localparam port_idx_t PORT0 = 1'b0;
   localparam port_idx_t PORT1 = 1'b1;

   // {port, op} doubles as the index of the upstream ack vector
   typedef struct packed {
      port_idx_t port;
      op_e       op;
   } xact_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of upstream port handshakes and the downstream RAM handshake.
// slave is the arbiter's view, master is the view of the clients and the RAM.
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                  p0ReadReq, p0WriteReq, p1ReadReq, p1WriteReq;
   logic [ADDR_WIDTH-1:0] p0Address, p1Address;
   logic [DATA_WIDTH-1:0] p0WriteData, p1WriteData;
   logic [DATA_WIDTH-1:0] p0ReadData, p1ReadData;
   logic                  p0ReadAck, p0WriteAck, p1ReadAck, p1WriteAck;
   logic [ADDR_WIDTH-1:0] ramAddress;
   logic [DATA_WIDTH-1:0] ramOut, ramValue;
   logic                  readReq, writeReq, readAck, writeAck;
   logic                  busy, timeoutErr;
   port_idx_t             grant;

   modport slave (
      input  p0ReadReq, p0WriteReq, p1ReadReq, p1WriteReq,
      input  p0Address, p1Address, p0WriteData, p1WriteData,
      input  ramValue, readAck, writeAck,
      output p0ReadData, p1ReadData, p0ReadAck, p0WriteAck, p1ReadAck, p1WriteAck,
      output ramAddress, ramOut, readReq, writeReq, busy, grant, timeoutErr
   );

   modport master (
      output p0ReadReq, p0WriteReq, p1ReadReq, p1WriteReq,
      output p0Address, p1Address, p0WriteData, p1WriteData,
      output ramValue, readAck, writeAck,
      input  p0ReadData, p1ReadData, p0ReadAck, p0WriteAck, p1ReadAck, p1WriteAck,
      input  ramAddress, ramOut, readReq, writeReq, busy, grant, timeoutErr
   );

endinterface

// File: rtl/ram_arb_timer.sv
// WAIT-phase cycle counter; expired_c flags the enabled cycle on which the
// count reaches TIMEOUT, so a transaction sees at most TIMEOUT WAIT cycles.
module ram_arb_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != CNT_W'(TIMEOUT))) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_c = en && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-request RAM: one
// transaction at a time through IDLE -> ISSUE -> WAIT -> DONE.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input logic          clk,
   input logic          reset,
   ram_arbiter_if.slave bus
);

   localparam int unsigned AW = ADDR_WIDTH;
   localparam int unsigned DW = DATA_WIDTH;

   state_e         state_q, state_d;
   xact_t          xact_q, xact_d;
   port_idx_t      ptr_q, ptr_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [DW-1:0]  wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic           rd_req_q, rd_req_d, wr_req_q, wr_req_d;
   logic [3:0]     ack_q, ack_d;
   logic           busy_q, busy_d, terr_q, terr_d;

   logic           p0_req_c, p1_req_c, ram_ack_c, expired_c, done_c;
   logic           timer_clr_c, timer_en_c;
   port_idx_t      win_c;
   op_e            win_op_c;

   // Pointer port wins a tie; a lone requester wins outright; read beats write
   assign p0_req_c    = bus.p0ReadReq | bus.p0WriteReq;
   assign p1_req_c    = bus.p1ReadReq | bus.p1WriteReq;
   assign win_c       = (p0_req_c && p1_req_c) ? ptr_q : (p0_req_c ? PORT0 : PORT1);
   assign win_op_c    = ((win_c == PORT1) ? bus.p1ReadReq : bus.p0ReadReq) ? OP_READ : OP_WRITE;
   assign ram_ack_c   = (xact_q.op == OP_READ) ? bus.readAck : bus.writeAck;
   assign timer_clr_c = (state_q == ST_ISSUE);
   assign timer_en_c  = (state_q == ST_WAIT);
   assign done_c      = timer_en_c && (ram_ack_c || expired_c);

   ram_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clr       (timer_clr_c),
      .en        (timer_en_c),
      .expired_c (expired_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (p0_req_c || p1_req_c) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (done_c) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      xact_d   = xact_q;
      ptr_d    = ptr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      rd_req_d = 1'b0;
      wr_req_d = 1'b0;
      ack_d    = '0;
      terr_d   = terr_q;
      busy_d   = (state_d != ST_IDLE);
      if ((state_q == ST_IDLE) && (p0_req_c || p1_req_c)) begin
         xact_d.port = win_c;
         xact_d.op   = win_op_c;
         ptr_d       = ~win_c;
         addr_d      = (win_c == PORT1) ? bus.p1Address : bus.p0Address;
         wdata_d     = (win_c == PORT1) ? bus.p1WriteData : bus.p0WriteData;
         rd_req_d    = (win_op_c == OP_READ);
         wr_req_d    = (win_op_c == OP_WRITE);
      end
      // A timed-out read completes with zero data and latches the error flag
      if (done_c) begin
         ack_d[{xact_q.port, xact_q.op}] = 1'b1;
         if (xact_q.op == OP_READ) begin
            if (xact_q.port == PORT1) begin
               rdata1_d = ram_ack_c ? bus.ramValue : '0;
            end else begin
               rdata0_d = ram_ack_c ? bus.ramValue : '0;
            end
         end
         if (!ram_ack_c) begin
            terr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xact_q   <= '0;
         ptr_q    <= PORT0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
         ack_q    <= '0;
         busy_q   <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         xact_q   <= xact_d;
         ptr_q    <= ptr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         rd_req_q <= rd_req_d;
         wr_req_q <= wr_req_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         terr_q   <= terr_d;
      end
   end

   assign bus.p0ReadData = rdata0_q;
   assign bus.p1ReadData = rdata1_q;
   assign bus.p0ReadAck  = ack_q[0];
   assign bus.p0WriteAck = ack_q[1];
   assign bus.p1ReadAck  = ack_q[2];
   assign bus.p1WriteAck = ack_q[3];
   assign bus.ramAddress = addr_q;
   assign bus.ramOut     = wdata_q;
   assign bus.readReq    = rd_req_q;
   assign bus.writeReq   = wr_req_q;
   assign bus.busy       = busy_q;
   assign bus.grant      = xact_q.port;
   assign bus.timeoutErr = terr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model compared every cycle at the
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_ram_arbiter;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // RAM stand-in: acks ram_delay cycles after seeing a request, unless muted
   int ram_delay = 1;
   bit ram_mute  = 1'b0;

   function automatic logic [31:0] ram_fn(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
   endfunction

   initial begin
      bit          rd;
      logic [31:0] a;
      int          d;
      bus.readAck  = 1'b0;
      bus.writeAck = 1'b0;
      bus.ramValue = 32'hBAD0BAD0;
      forever begin
         @(negedge clk);
         if ((bus.readReq || bus.writeReq) && !ram_mute) begin
            rd = bus.readReq;
            a  = bus.ramAddress;
            d  = ram_delay;
            repeat (d) @(posedge clk);
            #1;
            bus.readAck  = rd;
            bus.writeAck = !rd;
            bus.ramValue = rd ? ram_fn(a) : 32'hBAD0BAD0;
            @(posedge clk);
            #1;
            bus.readAck  = 1'b0;
            bus.writeAck = 1'b0;
            bus.ramValue = 32'hBAD0BAD0;
         end
      end
   end

   typedef struct {
      int          port;
      bit          rd;
      int          cyc;
      logic [31:0] data;
   } ack_rec_t;

   ack_rec_t   ack_log[$];
   logic [3:0] mon_ack = '0;
   int         n_rdreq = 0, n_wrreq = 0, n_overlap = 0;
   bit         chk_en  = 1'b0;

   function automatic ack_rec_t ack_at(input int i);
      ack_rec_t r;
      r = '{port: -1, rd: 1'b0, cyc: -1, data: 32'hFFFF_FFFF};
      if (i < ack_log.size()) r = ack_log[i];
      return r;
   endfunction

   // Model: one transaction record; age 0 = issue cycle, age k = k-th wait cycle
   bit          m_act = 0, m_done = 0, m_rd = 0, m_terr = 0;
   int          m_ptr = 0, m_port = 0, m_age = 0, win;
   logic [31:0] m_addr = '0, m_wdata = '0;
   logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
   logic [3:0]  e_acks, d_acks;
   bit          req0, req1, matched;

   always @(negedge clk) begin
      d_acks = {bus.p1WriteAck, bus.p1ReadAck, bus.p0WriteAck, bus.p0ReadAck};
      if (bus.readReq) n_rdreq++;
      if (bus.writeReq) n_wrreq++;
      if (bus.readReq && bus.writeReq) n_overlap++;
      for (int i = 0; i < 4; i++) begin
         if (d_acks[i]) ack_log.push_back('{port: i / 2, rd: (i % 2) == 0, cyc: cyc,
                                            data: (i / 2 == 1) ? bus.p1ReadData : bus.p0ReadData});
      end
      mon_ack = d_acks;

      e_acks = '0;
      if (m_done) e_acks[m_port * 2 + (m_rd ? 0 : 1)] = 1'b1;
      if (chk_en) begin
         chk("busy", bus.busy, m_act);
         chk("grant", bus.grant, m_port);
         chk("readReq", bus.readReq, m_act && !m_done && m_age == 0 && m_rd);
         chk("writeReq", bus.writeReq, m_act && !m_done && m_age == 0 && !m_rd);
         chk("ramAddress", bus.ramAddress, m_addr);
         chk("ramOut", bus.ramOut, m_wdata);
         chk("p0ReadData", bus.p0ReadData, m_rdata[0]);
         chk("p1ReadData", bus.p1ReadData, m_rdata[1]);
         chk("acks", d_acks, e_acks);
         chk("timeoutErr", bus.timeoutErr, m_terr);
      end

      req0 = bus.p0ReadReq || bus.p0WriteReq;
      req1 = bus.p1ReadReq || bus.p1WriteReq;
      if (reset) begin
         m_act = 0; m_done = 0; m_ptr = 0; m_port = 0; m_rd = 0; m_age = 0;
         m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0; m_terr = 0;
      end else if (!m_act) begin
         if (req0 || req1) begin
            win     = (req0 && req1) ? m_ptr : (req0 ? 0 : 1);
            m_ptr   = 1 - win;
            m_port  = win;
            m_rd    = (win == 1) ? bus.p1ReadReq : bus.p0ReadReq;
            m_addr  = (win == 1) ? bus.p1Address : bus.p0Address;
            m_wdata = (win == 1) ? bus.p1WriteData : bus.p0WriteData;
            m_act   = 1;
            m_age   = 0;
         end
      end else if (m_done) begin
         m_act  = 0;
         m_done = 0;
      end else if (m_age == 0) begin
         m_age = 1;
      end else begin
         matched = m_rd ? bus.readAck : bus.writeAck;
         if (matched || m_age == int'(TMO)) begin
            m_done = 1;
            if (m_rd) m_rdata[m_port] = matched ? bus.ramValue : 32'h0;
            if (!matched) m_terr = 1;
         end else begin
            m_age++;
         end
      end
   end

   bit auto_drop = 1'b1;

   // Advance one cycle to just after the rising edge; clients drop an acked request
   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_drop) begin
         if (mon_ack[0]) bus.p0ReadReq  = 1'b0;
         if (mon_ack[1]) bus.p0WriteReq = 1'b0;
         if (mon_ack[2]) bus.p1ReadReq  = 1'b0;
         if (mon_ack[3]) bus.p1WriteReq = 1'b0;
      end
   endtask

   task automatic wait_acks(input int n, input int budget);
      int k = 0;
      while (ack_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      if (ack_log.size() < n) chk("ack_wait_budget", ack_log.size(), n);
   endtask

   task automatic chk_ack(input string name, input int idx, input int port, input bit rd);
      chk({name, "_port"}, ack_at(idx).port, port);
      chk({name, "_rd"}, ack_at(idx).rd, rd);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.p0ReadReq = 0; bus.p0WriteReq = 0; bus.p1ReadReq = 0; bus.p1WriteReq = 0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int k, nr, nw, no, rc, c0;
      bus.p0ReadReq = 0; bus.p0WriteReq = 0; bus.p1ReadReq = 0; bus.p1WriteReq = 0;
      bus.p0Address = '0; bus.p1Address = '0; bus.p0WriteData = '0; bus.p1WriteData = '0;
      do_reset();
      chk_en = 1'b1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_readReq", bus.readReq, 0);
      chk("rst_ramAddress", bus.ramAddress, 0);

      // Single read from p0
      k = ack_log.size(); nr = n_rdreq; nw = n_wrreq;
      bus.p0Address = 32'h10; bus.p0ReadReq = 1; rc = cyc;
      wait_acks(k + 1, 20);
      tick();
      chk_ack("rd_p0", k, 0, 1);
      chk("rd_p0_data", ack_at(k).data, 32'hDEADBEEF);
      chk("rd_p0_latency", ack_at(k).cyc - rc + 1, 4);
      chk("rd_p0_readReq_cycles", n_rdreq - nr, 1);
      chk("rd_p0_writeReq_cycles", n_wrreq - nw, 0);

      // RAM silent: forced completion after TMO wait cycles
      k = ack_log.size();
      ram_mute = 1; bus.p0Address = 32'h14; bus.p0ReadReq = 1; rc = cyc;
      wait_acks(k + 1, 30);
      ram_mute = 0;
      chk_ack("tmo", k, 0, 1);
      chk("tmo_data", ack_at(k).data, 32'h0);
      chk("tmo_latency", ack_at(k).cyc - rc + 1, 11);
      chk("tmo_err", bus.timeoutErr, 1);
      repeat (5) tick();
      chk("tmo_err_sticky", bus.timeoutErr, 1);
      do_reset();
      chk("tmo_err_cleared", bus.timeoutErr, 0);

      // Simultaneous p0 write and p1 read after reset
      k = ack_log.size(); nr = n_rdreq; nw = n_wrreq; no = n_overlap;
      bus.p0Address = 32'h20; bus.p0WriteData = 32'hCAFEF00D; bus.p0WriteReq = 1;
      bus.p1Address = 32'h30; bus.p1ReadReq = 1;
      wait_acks(k + 2, 40);
      tick();
      chk_ack("pair_first", k, 0, 0);
      chk_ack("pair_second", k + 1, 1, 1);
      chk("pair_p1_data", ack_at(k + 1).data, 32'h0030C0DE);
      chk("pair_overlap", n_overlap - no, 0);
      chk("pair_readReq_cycles", n_rdreq - nr, 1);
      chk("pair_writeReq_cycles", n_wrreq - nw, 1);

      // Both ports request continuously: grants alternate
      do_reset();
      k = ack_log.size(); auto_drop = 0;
      bus.p0Address = 32'h100; bus.p1Address = 32'h104;
      bus.p0ReadReq = 1; bus.p1ReadReq = 1;
      wait_acks(k + 8, 100);
      bus.p0ReadReq = 0; bus.p1ReadReq = 0; auto_drop = 1;
      c0 = 0;
      for (int i = 0; i < 8; i++) begin
         chk("rr_grant_order", ack_at(k + i).port, i % 2);
         if (ack_at(k + i).port == 0) c0++;
      end
      chk("rr_p0_acks", c0, 4);
      chk("rr_p1_data", ack_at(k + 7).data, 32'h0104C0DE);
      repeat (4) tick();

      // p1 read and write together: read first, write on the next grant
      do_reset();
      k = ack_log.size();
      bus.p1Address = 32'h40; bus.p1WriteData = 32'h12345678;
      bus.p1ReadReq = 1; bus.p1WriteReq = 1;
      wait_acks(k + 2, 40);
      tick();
      chk_ack("rw_first", k, 1, 1);
      chk_ack("rw_second", k + 1, 1, 0);
      chk("rw_read_data", ack_at(k).data, 32'h0040C0DE);

      // Reset while waiting; the late RAM ack must be ignored
      do_reset();
      k = ack_log.size(); ram_delay = 4;
      bus.p0Address = 32'h50; bus.p0ReadReq = 1;
      tick();
      tick();
      chk("mid_rst_busy_in_wait", bus.busy, 1);
      reset = 1; bus.p0ReadReq = 0;
      tick();
      reset = 0;
      repeat (8) tick();
      ram_delay = 1;
      chk("mid_rst_no_ack", ack_log.size(), k);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_readReq", bus.readReq, 0);
      chk("mid_rst_ramAddress", bus.ramAddress, 0);
      chk("mid_rst_p0ReadData", bus.p0ReadData, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, width of all data ports.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before forced completion.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 p0ReadReq, p1ReadReq  in  1  level read request, held until the port's ack.
REQ-007 p0WriteReq, p1WriteReq  in  1  level write request, held until the port's ack.
REQ-008 p0Address, p1Address  in  ADDR_WIDTH  byte address, stable while request high.
REQ-009 p0WriteData, p1WriteData  in  DATA_WIDTH  write data, stable while write request high.
REQ-010 p0ReadData, p1ReadData  out  DATA_WIDTH  registered read data, valid with the port's readAck.
REQ-011 p0ReadAck, p0WriteAck, p1ReadAck, p1WriteAck  out  1  one-cycle completion pulses.
REQ-012 ramAddress  out  ADDR_WIDTH; ramOut  out  DATA_WIDTH; readReq, writeReq  out  1  downstream request.
REQ-013 ramValue  in  DATA_WIDTH; readAck, writeAck  in  1  downstream response (one-cycle pulse).
REQ-014 busy  out  1  high in any state other than IDLE; grant  out  1  port owning the current transaction.
REQ-015 timeoutErr  out  1  sticky, set on any timeout, cleared only by reset.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE; one transaction outstanding at a time.
REQ-017 IDLE: sample both ports; on any request latch port, op, address and write data into registers, set grant, go ISSUE.
REQ-018 Arbitration: round-robin pointer; if both ports request, the pointer port wins; the pointer moves to the other port after every grant.
REQ-019 If only one port requests, it wins regardless of the pointer; the pointer still moves to the other port.
REQ-020 Read and write asserted together on one port: read is served; write stays pending for a later grant.
REQ-021 ISSUE: drive readReq or writeReq high for exactly one cycle with latched address/data, go WAIT.
REQ-022 WAIT: readReq/writeReq low; ramAddress/ramOut hold latched values; increment wait counter each cycle.
REQ-023 WAIT: on the readAck or writeAck matching the latched op, capture ramValue (reads), pulse that ack to the granted port, go DONE.
REQ-024 DONE: ack pulse visible for this one cycle; return to IDLE; the requester's lowered request is therefore seen in IDLE.
REQ-025 Timeout: counter reaching TIMEOUT in WAIT completes the transaction with read data 0, sets timeoutErr, goes DONE.
REQ-026 Downstream acks outside WAIT, or of the non-matching op, are ignored.
REQ-027 Minimum latency from request sample to upstream ack: 4 cycles with a 1-cycle-turnaround RAM.
REQ-028 Non-granted port outputs: all acks 0; its ReadData holds its last value.

Reset
REQ-029 Reset forces IDLE, pointer=port0, grant=0, busy=0, timeoutErr=0, wait counter=0.
REQ-030 Reset forces all acks, readReq, writeReq to 0; ramAddress, ramOut, p0ReadData, p1ReadData to 0.
REQ-031 Reset mid-transaction abandons it without an upstream ack; a late downstream ack is then ignored per REQ-026.

Structure
REQ-032 Shared package holds FSM state encoding, op encoding (READ, WRITE) and the port index type.
REQ-033 One sub-module, ram_arb_timer: wait counter with clear, enable and expiry flag at TIMEOUT.

Verification
REQ-034 p0 read 0x10, RAM returns 0xDEADBEEF -> p0ReadAck one cycle, p0ReadData=0xDEADBEEF, readReq high exactly one cycle.
REQ-035 p0 write 0x20 and p1 read 0x30 in the same cycle after reset -> p0 served first, then p1; no overlapping downstream requests.
REQ-036 Both ports request continuously for 8 transactions -> grants alternate 0,1,0,1,...; 4 acks each.
REQ-037 RAM never acks, TIMEOUT=8 -> upstream ack after 8 WAIT cycles, ReadData=0, timeoutErr=1 until reset.
REQ-038 Reset asserted in WAIT, then RAM acks -> no upstream ack, FSM stays IDLE, all outputs at reset values.
REQ-039 p1 asserts ReadReq and WriteReq together -> read served first, write served on the next p1 grant.
